lsu_ctrl: RTL and testbench

Load/store sequencing controller between the execute stage and the word-wide data memory port. Accepts one load or store per handshake, drives word-aligned memory transactions with byte enables, and splits misaligned accesses into two consecutive word transactions. For loads, it merges the returned words, aligns and sign/zero-extends the result, and presents it for register writeback. It replaces the purely combinational load-alignment path with a multi-cycle handshaken unit.

---
 rtl/lsu_ctrl_if.sv | 40 ++++
 rtl/lsu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Bundle of execute-side request, memory-port and writeback signals for lsu_ctrl.
// slave is the controller's view; master is the surrounding pipeline/memory view.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    // Handshakes: a request transfers on a rising edge where req_valid & req_ready;
    // a memory access completes on a rising edge where mem_req & mem_ack.
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output wb_valid, wb_rd, wb_data, err
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  wb_valid, wb_rd, wb_data, err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: word-aligned memory accesses with byte enables, misaligned
// accesses split into two words, load results merged, aligned and extended.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    lsu_ctrl_if.slave   bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_e;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        bad_q, bad_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;

    logic        req_ready;
    logic        illegal_req;
    logic [1:0]  off;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic        split;
    logic [63:0] wd64;
    logic [31:0] word_addr;
    logic [63:0] raw64;
    logic [31:0] r;
    logic [31:0] ld_result;

    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        wb_valid, err;

    assign req_ready = (state_q == IDLE) & rst_n;

    assign illegal_req = bus.req_write ? (bus.req_funct3 >= 3'b011)
                                       : ((bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11));

    // Lane geometry is derived from the latched request so the bus stays stable while waiting.
    always_comb begin
        off       = addr_q[1:0];
        case (funct3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask = {4'b0000, size_mask} << off;
        split     = |lane_mask[7:4];
        wd64      = {32'b0, wdata_q} << {off, 3'b000};
        word_addr = {addr_q[31:2], 2'b00};
    end

    // The final ack's data is folded straight into the result, so RESP needs no extra cycle.
    always_comb begin
        raw64 = (state_q == ACC1) ? {bus.mem_rdata, lo_q} : {32'b0, bus.mem_rdata};
        r     = 32'(raw64 >> {off, 3'b000});
        case (funct3_q)
            3'b000:  ld_result = {{24{r[7]}}, r[7:0]};
            3'b100:  ld_result = {24'b0, r[7:0]};
            3'b001:  ld_result = {{16{r[15]}}, r[15:0]};
            3'b101:  ld_result = {16'b0, r[15:0]};
            default: ld_result = r;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        bad_d     = bad_q;
        lo_d      = lo_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'b0;
        mem_be    = 4'b0;
        mem_wdata = 32'b0;
        wb_valid  = 1'b0;
        err       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rd_d     = bus.req_rd;
                    bad_d    = illegal_req;
                    state_d  = illegal_req ? RESP : ACC0;
                end
            end
            ACC0: begin
                mem_req   = 1'b1;
                mem_we    = write_q;
                mem_addr  = word_addr;
                mem_be    = lane_mask[3:0];
                mem_wdata = wd64[31:0];
                if (bus.mem_ack) begin
                    lo_d = bus.mem_rdata;
                    if (split) begin
                        state_d = ACC1;
                    end else if (write_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = RESP;
                        wb_data_d = ld_result;
                        wb_rd_d   = rd_q;
                    end
                end
            end
            ACC1: begin
                mem_req   = 1'b1;
                mem_we    = write_q;
                mem_addr  = word_addr + 32'd4;
                mem_be    = lane_mask[7:4];
                mem_wdata = wd64[63:32];
                if (bus.mem_ack) begin
                    if (write_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = RESP;
                        wb_data_d = ld_result;
                        wb_rd_d   = rd_q;
                    end
                end
            end
            default: begin
                wb_valid = ~bad_q;
                err      = bad_q;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            funct3_q  <= 3'b0;
            addr_q    <= 32'b0;
            wdata_q   <= 32'b0;
            rd_q      <= 5'b0;
            bad_q     <= 1'b0;
            lo_q      <= 32'b0;
            wb_data_q <= 32'b0;
            wb_rd_q   <= 5'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            bad_q     <= bad_d;
            lo_q      <= lo_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_be    = mem_be;
    assign bus.mem_wdata = mem_wdata;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err       = err;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-level reference memory predicts memory transactions and
// load results; a responder and a writeback monitor pop and compare independently.
module tb_lsu_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    lsu_ctrl_if bus();

    lsu_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fixed_wait = -1;

    // {is_err, rd, data}
    logic [37:0] exp_q[$];
    // {we, addr, be, wdata}
    logic [68:0] mem_exp_q[$];

    logic [7:0]  ref_mem[logic [31:0]];
    logic [31:0] wmem[logic [31:0]];

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] resp_word(input logic [31:0] w);
        if (wmem.exists(w)) return wmem[w];
        return {init_byte(w + 32'd3), init_byte(w + 32'd2), init_byte(w + 32'd1), init_byte(w)};
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        wmem[a] = w;
        for (int j = 0; j < 4; j++) ref_mem[a + 32'(j)] = w[8*j +: 8];
    endtask

    // Memory responder: checks each transaction on arrival, holds it for some wait
    // states while checking stability, then acks.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_req) begin
                logic [68:0] got, cur, e;
                logic [31:0] w;
                int waits;
                bit aborted;
                got = {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
                if (mem_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: got txn %0h expected none", got);
                end else begin
                    e = mem_exp_q.pop_front();
                    check("mem_we", got[68], e[68]);
                    check("mem_addr", got[67:36], e[67:36]);
                    check("mem_be", got[35:32], e[35:32]);
                    if (e[68]) check("mem_wdata", got[31:0], e[31:0]);
                end
                waits = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
                aborted = 1'b0;
                for (int k = 0; k < waits; k++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    cur = {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
                    check("mem_stable_req", bus.mem_req, 1'b1);
                    check("mem_stable", cur, got);
                end
                if (!aborted) begin
                    bus.mem_rdata = resp_word(bus.mem_addr);
                    bus.mem_ack   = 1'b1;
                    if (bus.mem_we) begin
                        w = resp_word(bus.mem_addr);
                        for (int j = 0; j < 4; j++)
                            if (bus.mem_be[j]) w[8*j +: 8] = bus.mem_wdata[8*j +: 8];
                        wmem[bus.mem_addr] = w;
                    end
                    @(posedge clk);
                    #1;
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end
        end
    end

    // Writeback / error monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wb_valid || bus.err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got wb_valid=%0b err=%0b expected none", bus.wb_valid, bus.err);
                end else begin
                    logic [37:0] e;
                    e = exp_q.pop_front();
                    check("resp_kind", {bus.err, bus.wb_valid}, e[37] ? 2'b10 : 2'b01);
                    if (!e[37]) begin
                        check("wb_rd", bus.wb_rd, e[36:32]);
                        check("wb_data", bus.wb_data, e[31:0]);
                    end
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int t;
        int n;
        bit bad;
        bit split;
        logic [31:0] first, b, val;
        logic [3:0]  be[2];
        logic [31:0] wd[2];
        int idx;
        @(negedge clk);
        t = 0;
        while (!bus.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 200 cycles");
            return;
        end
        bad = wr ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (bad) begin
            exp_q.push_back({1'b1, rd, 32'b0});
        end else begin
            first = addr & 32'hFFFF_FFFC;
            be[0] = 4'b0; be[1] = 4'b0;
            wd[0] = 32'b0; wd[1] = 32'b0;
            split = 1'b0;
            for (int i = 0; i < 4; i++) begin
                b = addr + 32'(i);
                idx = ((b & 32'hFFFF_FFFC) == first) ? 0 : 1;
                wd[idx][8*b[1:0] +: 8] = wdata[8*i +: 8];
                if (i < n) begin
                    be[idx][b[1:0]] = 1'b1;
                    if (idx == 1) split = 1'b1;
                end
            end
            mem_exp_q.push_back({wr, first, be[0], wr ? wd[0] : 32'b0});
            if (split) mem_exp_q.push_back({wr, first + 32'd4, be[1], wr ? wd[1] : 32'b0});
            if (!wr) begin
                val = 32'b0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = ref_byte(addr + 32'(i));
                if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
                if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
                exp_q.push_back({1'b0, rd, val});
            end else begin
                for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
            end
        end
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic wait_idle();
        int t;
        @(negedge clk);
        t = 0;
        while ((!bus.req_ready || exp_q.size() != 0 || mem_exp_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle within 300 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       wr;
        logic [2:0] f3;
        logic [31:0] a;
        int t;

        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'b0; bus.req_wdata = 32'b0; bus.req_rd = 5'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'b0);
        check("rst_mem_be", bus.mem_be, 4'b0);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_wb_data", bus.wb_data, 32'b0);
        check("rst_wb_rd", bus.wb_rd, 5'b0);
        check("rst_err", bus.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1'b1);

        preload(32'h100, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd1);
        wait_idle();
        check("lw_aligned", bus.wb_data, 32'hDEADBEEF);

        preload(32'h100, 32'h80FF1234);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd2);
        wait_idle();
        check("lb_sign", bus.wb_data, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd3);
        wait_idle();
        check("lbu_zero", bus.wb_data, 32'h00000080);

        preload(32'h100, 32'h33221100);
        preload(32'h104, 32'h77665544);
        issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd4);
        wait_idle();
        check("lw_split", bus.wb_data, 32'h55443322);

        issue(1'b1, 3'b001, 32'h103, 32'h0000ABCD, 5'd5);
        wait_idle();
        check("sh_split_lo", wmem[32'h100][31:24], 8'hCD);
        check("sh_split_hi", wmem[32'h104][7:0], 8'hAB);

        fixed_wait = 3;
        preload(32'hFFFFFFFC, 32'hAABBCCDD);
        preload(32'h0, 32'h11223344);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd6);
        wait_idle();
        check("lw_wrap", bus.wb_data, 32'h3344AABB);
        fixed_wait = -1;

        issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd7);
        wait_idle();
        issue(1'b1, 3'b101, 32'h100, 32'h0, 5'd8);
        wait_idle();

        fixed_wait = 6;
        issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd9);
        @(negedge clk);
        t = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h104) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("reach_acc1", bus.mem_addr, 32'h104);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", bus.mem_req, 1'b0);
        check("midrst_wb_valid", bus.wb_valid, 1'b0);
        check("midrst_wb_data", bus.wb_data, 32'b0);
        exp_q.delete();
        mem_exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fixed_wait = -1;
        @(negedge clk);
        check("midrst_ready", bus.req_ready, 1'b1);
        check("midrst_state", dbg_state, 2'd0);

        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                f3 = wr ? 3'($urandom_range(3, 7)) : ((($urandom_range(0, 2)) == 0) ? 3'd3 : 3'($urandom_range(6, 7)));
            end else if (wr) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : 32'h200 + 32'($urandom_range(0, 63));
            issue(wr, f3, a, $urandom, 5'($urandom_range(0, 31)));
        end
        wait_idle();
        check("exp_q_drained", exp_q.size(), 0);
        check("mem_exp_q_drained", mem_exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
